picorv32_trace_capture: RTL and testbench

PICORV32_TRACE_CAPTURE -- requirements
Module: picorv32_trace_capture

---
 rtl/picorv32_trace_pkg.sv | 37 +++
 rtl/trace_fifo.sv | 98 +++++++++
 rtl/picorv32_trace_capture.sv | 219 +++++++++++++++++++++
 tb/tb_picorv32_trace_capture.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_trace_pkg.sv
// Shared definitions for the picorv32 trace capture block: register map,
// CTRL/STATUS bit positions, FSM encodings and small helpers.
package picorv32_trace_pkg;

    localparam int TRACE_W = 36;

    localparam logic [2:0] ADR_CTRL    = 3'd0;
    localparam logic [2:0] ADR_STATUS  = 3'd1;
    localparam logic [2:0] ADR_DATA_LO = 3'd2;
    localparam logic [2:0] ADR_DATA_HI = 3'd3;
    localparam logic [2:0] ADR_THRESH  = 3'd4;
    localparam logic [2:0] ADR_DROPPED = 3'd5;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CTRL_STOP_BIT   = 2;

    localparam int STAT_EMPTY_BIT   = 0;
    localparam int STAT_FULL_BIT    = 1;
    localparam int STAT_OVF_BIT     = 2;
    localparam int STAT_STOPPED_BIT = 3;
    localparam int STAT_COUNT_LSB   = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_STOPPED = 2'd2;

    // Saturating increment so the drop counter never wraps back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace word FIFO: 2**DEPTH_LOG2 x 36 storage, push/pop/flush, fill count and
// a registered head word that is valid whenever the FIFO is not empty.
module trace_fifo
    import picorv32_trace_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [TRACE_W-1:0]    i_data,
    output logic [TRACE_W-1:0]    o_head,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [TRACE_W-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [TRACE_W-1:0]    r_head;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_eff;
    logic                  w_pop_eff;
    logic [DEPTH_LOG2-1:0] w_rd_next;

    assign w_empty    = (r_count == {(DEPTH_LOG2 + 1){1'b0}});
    assign w_full     = (r_count == FULL_CNT);
    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign w_push_eff = i_push & (~w_full | i_pop) & ~i_flush;
    assign w_pop_eff  = i_pop & ~w_empty & ~i_flush;

    // Read pointer after this cycle's pop, used to prefetch the next head word.
    always_comb begin
        if (w_pop_eff) begin
            w_rd_next = r_rd_ptr + DEPTH_LOG2'(1);
        end else begin
            w_rd_next = r_rd_ptr;
        end
    end

    // Storage array write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_push_eff) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and fill-count bookkeeping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr <= {DEPTH_LOG2{1'b0}};
            r_count  <= {(DEPTH_LOG2 + 1){1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr <= {DEPTH_LOG2{1'b0}};
            r_count  <= {(DEPTH_LOG2 + 1){1'b0}};
        end else begin
            if (w_push_eff) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            r_rd_ptr <= w_rd_next;
            if (w_push_eff && !w_pop_eff) begin
                r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
            end else if (!w_push_eff && w_pop_eff) begin
                r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

    // Head register; bypasses the incoming word when it becomes the new head.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_head <= {TRACE_W{1'b0}};
        end else if (i_flush) begin
            r_head <= {TRACE_W{1'b0}};
        end else if (w_push_eff && (r_wr_ptr == w_rd_next)) begin
            r_head <= i_data;
        end else begin
            r_head <= r_mem[w_rd_next];
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/picorv32_trace_capture.sv
// Captures picorv32 trace words into a FIFO under control of a small
// Wishbone classic register file, with trap-stop and fill-level interrupt.
module picorv32_trace_capture
    import picorv32_trace_pkg::*;
#(
    parameter int DEPTH_LOG2       = 9,
    parameter bit STOP_ON_TRAP_DEF = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                trace_valid_i,
    input  logic [TRACE_W-1:0]  trace_data_i,
    input  logic                trap_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [2:0]          wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    input  logic [3:0]          wb_sel_i,
    output logic                wb_ack_o,
    output logic [31:0]         wb_dat_o,
    output logic                irq_o
);

    localparam int CW = DEPTH_LOG2 + 1;

    logic [1:0]          r_state;
    logic                r_enable;
    logic                r_stop_on_trap;
    logic                r_overflow;
    logic [31:0]         r_dropped;
    logic [CW-1:0]       r_thresh;
    logic                r_ack;
    logic [31:0]         r_dat;
    logic                r_pop_pend;
    logic                r_irq;

    logic [1:0]          w_state_nxt;
    logic                w_req;
    logic                w_acc;
    logic                w_wr;
    logic                w_ctrl_wr;
    logic                w_clear;
    logic                w_en_new;
    logic                w_push_req;
    logic                w_fifo_push;
    logic                w_pop;
    logic                w_drop;
    logic [31:0]         w_rd_data;
    logic [TRACE_W-1:0]  w_head;
    logic [CW-1:0]       w_count;
    logic                w_empty;
    logic                w_full;
    logic                w_unused;

    assign w_unused = ^{wb_dat_i, wb_sel_i[3:1]};

    // The request is sampled while ack is low; all side effects happen on the ack cycle.
    assign w_req       = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_acc       = wb_cyc_i & wb_stb_i & r_ack;
    assign w_wr        = w_acc & wb_we_i;
    assign w_ctrl_wr   = w_wr & (wb_adr_i == ADR_CTRL) & wb_sel_i[0];
    assign w_clear     = w_ctrl_wr & wb_dat_i[CTRL_CLEAR_BIT];
    assign w_en_new    = w_ctrl_wr ? wb_dat_i[CTRL_ENABLE_BIT] : r_enable;
    assign w_push_req  = (r_state == ST_ARMED) & trace_valid_i;
    assign w_fifo_push = w_push_req & ~w_clear;
    assign w_pop       = w_acc & r_pop_pend;
    assign w_drop      = w_fifo_push & w_full & ~w_pop;

    trace_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_push  (w_fifo_push),
        .i_pop   (w_pop),
        .i_flush (w_clear),
        .i_data  (trace_data_i),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Capture state machine next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ctrl_wr && w_en_new) begin
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (w_ctrl_wr && !w_en_new) begin
                    w_state_nxt = ST_IDLE;
                end else if (trap_i && r_stop_on_trap) begin
                    w_state_nxt = ST_STOPPED;
                end else begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_STOPPED: begin
                if (w_ctrl_wr && !w_en_new) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_clear) begin
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_state_nxt = ST_STOPPED;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Register read multiplexer; data registers return zero while the FIFO is empty.
    always_comb begin
        w_rd_data = 32'd0;
        case (wb_adr_i)
            ADR_CTRL: begin
                w_rd_data[CTRL_ENABLE_BIT] = r_enable;
                w_rd_data[CTRL_STOP_BIT]   = r_stop_on_trap;
            end
            ADR_STATUS: begin
                w_rd_data[STAT_EMPTY_BIT]          = w_empty;
                w_rd_data[STAT_FULL_BIT]           = w_full;
                w_rd_data[STAT_OVF_BIT]            = r_overflow;
                w_rd_data[STAT_STOPPED_BIT]        = (r_state == ST_STOPPED);
                w_rd_data[STAT_COUNT_LSB +: 16]    = 16'(w_count);
            end
            ADR_DATA_LO: begin
                if (w_empty) begin
                    w_rd_data = 32'd0;
                end else begin
                    w_rd_data = w_head[31:0];
                end
            end
            ADR_DATA_HI: begin
                if (w_empty) begin
                    w_rd_data = 32'd0;
                end else begin
                    w_rd_data = {28'd0, w_head[35:32]};
                end
            end
            ADR_THRESH:  w_rd_data = 32'(r_thresh);
            ADR_DROPPED: w_rd_data = r_dropped;
            default:     w_rd_data = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Software-writable control and threshold registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_enable       <= 1'b0;
            r_stop_on_trap <= STOP_ON_TRAP_DEF;
            r_thresh       <= {CW{1'b0}};
        end else begin
            if (w_ctrl_wr) begin
                r_enable       <= wb_dat_i[CTRL_ENABLE_BIT];
                r_stop_on_trap <= wb_dat_i[CTRL_STOP_BIT];
            end
            if (w_wr && (wb_adr_i == ADR_THRESH)) begin
                r_thresh <= wb_dat_i[CW-1:0];
            end
        end
    end

    // Overflow flag and dropped-word counter; clear wins over a same-cycle drop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_overflow <= 1'b0;
            r_dropped  <= 32'd0;
        end else if (w_clear) begin
            r_overflow <= 1'b0;
            r_dropped  <= 32'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_dropped  <= sat_inc32(r_dropped);
        end
    end

    // Wishbone ack, read data and pending-pop tracking.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ack      <= 1'b0;
            r_dat      <= 32'd0;
            r_pop_pend <= 1'b0;
        end else begin
            r_ack      <= w_req;
            r_dat      <= (w_req && !wb_we_i) ? w_rd_data : 32'd0;
            r_pop_pend <= w_req & ~wb_we_i & (wb_adr_i == ADR_DATA_HI) & ~w_empty;
        end
    end

    // Fill-level interrupt, active only while capture is armed or stopped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ((r_state == ST_ARMED) || (r_state == ST_STOPPED)) && (w_count >= r_thresh);
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_picorv32_trace_capture.sv
// Directed bench for picorv32_trace_capture with a 4-deep FIFO.
module tb_picorv32_trace_capture;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        trace_valid_i;
    logic [35:0] trace_data_i;
    logic        trap_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [2:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        irq_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    picorv32_trace_capture #(
        .DEPTH_LOG2       (2),
        .STOP_ON_TRAP_DEF (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .trace_valid_i (trace_valid_i),
        .trace_data_i  (trace_data_i),
        .trap_i        (trap_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_we_i       (wb_we_i),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_sel_i      (wb_sel_i),
        .wb_ack_o      (wb_ack_o),
        .wb_dat_o      (wb_dat_o),
        .irq_o         (irq_o)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        logic ok;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = wdat; wb_sel_i = 4'hF;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        rdat = wb_dat_o;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check_vec("wb_ack_seen", 64'(ok), 64'd1);
    endtask

    task automatic wb_wr(input logic [2:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic wb_rd(input logic [2:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 32'd0, rdat);
    endtask

    task automatic push_word(input logic [35:0] d, input logic trap);
        @(negedge clk);
        trace_valid_i = 1'b1; trace_data_i = d; trap_i = trap;
        @(negedge clk);
        trace_valid_i = 1'b0; trap_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [35:0] w [6];
        logic [35:0] exp_q [4];
        logic [35:0] wn;

        rst_n_i = 1'b0; trace_valid_i = 1'b0; trace_data_i = 36'd0; trap_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 3'd0; wb_dat_i = 32'd0; wb_sel_i = 4'h0;
        for (int i = 0; i < 6; i++) w[i] = {4'(i + 4), 32'h0000_0100 + 32'(i)};
        wn = 36'hF_CAFE_0042;

        repeat (3) @(posedge clk);
        #1;
        check_vec("rst_ack", 64'(wb_ack_o), 64'd0);
        check_vec("rst_dat", 64'(wb_dat_o), 64'd0);
        check_vec("rst_irq", 64'(irq_o), 64'd0);
        @(negedge clk); rst_n_i = 1'b1;
        wb_rd(3'd1, rd); check_vec("rst_status", 64'(rd), 64'h1);
        wb_rd(3'd0, rd); check_vec("rst_ctrl", 64'(rd), 64'h4);
        wb_rd(3'd4, rd); check_vec("rst_thresh", 64'(rd), 64'h0);
        wb_rd(3'd5, rd); check_vec("rst_dropped", 64'(rd), 64'h0);

        // Basic capture and in-order readout
        wb_wr(3'd0, 32'h5);
        push_word(36'h1_0000_0001, 1'b0);
        push_word(36'h2_0000_0002, 1'b0);
        push_word(36'h3_0000_0003, 1'b0);
        wb_rd(3'd1, rd); check_vec("basic_status", 64'(rd), 64'h0003_0000);
        for (int i = 1; i <= 3; i++) begin
            wb_rd(3'd2, rd); check_vec("basic_lo", 64'(rd), 64'(i));
            wb_rd(3'd3, rd); check_vec("basic_hi", 64'(rd), 64'(i));
        end
        wb_rd(3'd1, rd); check_vec("basic_empty", 64'(rd), 64'h1);

        // Overflow: 6 pushes into 4 slots
        for (int i = 0; i < 6; i++) push_word(w[i], 1'b0);
        wb_rd(3'd1, rd); check_vec("ovf_status", 64'(rd), 64'h0004_0006);
        wb_rd(3'd5, rd); check_vec("ovf_dropped", 64'(rd), 64'd2);
        wb_rd(3'd2, rd); check_vec("ovf_head_lo", 64'(rd), 64'h100);

        // Pop and push on the same edge while full
        fork
            wb_rd(3'd3, rd);
            begin
                @(negedge clk);
                push_word(wn, 1'b0);
            end
        join
        check_vec("pp_hi", 64'(rd), 64'h4);
        wb_rd(3'd1, rd); check_vec("pp_status", 64'(rd), 64'h0004_0006);
        wb_rd(3'd5, rd); check_vec("pp_dropped", 64'(rd), 64'd2);
        exp_q[0] = w[1]; exp_q[1] = w[2]; exp_q[2] = w[3]; exp_q[3] = wn;
        for (int i = 0; i < 4; i++) begin
            wb_rd(3'd2, rd); check_vec("drain_lo", 64'(rd), 64'(exp_q[i][31:0]));
            wb_rd(3'd3, rd); check_vec("drain_hi", 64'(rd), 64'(exp_q[i][35:32]));
        end
        wb_rd(3'd1, rd); check_vec("drain_status", 64'(rd), 64'h5);
        wb_wr(3'd0, 32'h7);
        wb_rd(3'd1, rd); check_vec("clr_status", 64'(rd), 64'h1);
        wb_rd(3'd5, rd); check_vec("clr_dropped", 64'(rd), 64'd0);

        // Trap stops capture but keeps the trap-cycle word
        push_word(36'h1_AAAA_0001, 1'b0);
        push_word(36'h2_BBBB_0002, 1'b1);
        push_word(36'h3_CCCC_0003, 1'b0);
        wb_rd(3'd1, rd); check_vec("trap_status", 64'(rd), 64'h0002_0008);
        wb_rd(3'd2, rd); check_vec("trap_head_lo", 64'(rd), 64'hAAAA_0001);
        wb_wr(3'd0, 32'h7);
        wb_rd(3'd1, rd); check_vec("rearm_status", 64'(rd), 64'h1);
        push_word(36'h3_DDDD_0003, 1'b0);
        wb_rd(3'd1, rd); check_vec("rearm_push", 64'(rd), 64'h0001_0000);
        wb_rd(3'd3, rd); check_vec("rearm_hi", 64'(rd), 64'h3);

        // Threshold interrupt and empty read
        wb_wr(3'd4, 32'h2);
        wb_rd(3'd4, rd); check_vec("thresh_rd", 64'(rd), 64'h2);
        @(posedge clk); #1; check_vec("irq_below", 64'(irq_o), 64'd0);
        push_word(36'h5_0000_0E0E, 1'b0);
        push_word(36'h6_0000_0F0F, 1'b0);
        @(posedge clk); #1; check_vec("irq_at", 64'(irq_o), 64'd1);
        wb_rd(3'd3, rd); check_vec("irq_pop_hi", 64'(rd), 64'h5);
        @(posedge clk); #1; check_vec("irq_drop", 64'(irq_o), 64'd0);
        wb_rd(3'd3, rd); check_vec("irq_pop2_hi", 64'(rd), 64'h6);
        wb_rd(3'd3, rd); check_vec("empty_hi", 64'(rd), 64'h0);
        wb_rd(3'd1, rd); check_vec("empty_status", 64'(rd), 64'h1);

        // Reset in the middle of an acked access
        push_word(36'h1_1111_1111, 1'b0);
        push_word(36'h2_2222_2222, 1'b0);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 3'd1;
        @(posedge clk); #1;
        check_vec("mid_ack_pre", 64'(wb_ack_o), 64'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check_vec("mid_ack_rst", 64'(wb_ack_o), 64'd0);
        check_vec("mid_dat_rst", 64'(wb_dat_o), 64'd0);
        check_vec("mid_irq_rst", 64'(irq_o), 64'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        wb_rd(3'd1, rd); check_vec("post_status", 64'(rd), 64'h1);
        wb_rd(3'd5, rd); check_vec("post_dropped", 64'(rd), 64'd0);
        wb_rd(3'd0, rd); check_vec("post_ctrl", 64'(rd), 64'h4);
        wb_rd(3'd4, rd); check_vec("post_thresh", 64'(rd), 64'h0);
        push_word(36'h7_7777_7777, 1'b0);
        wb_rd(3'd1, rd); check_vec("idle_nopush", 64'(rd), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
